// File: rtl/position_alert_if.sv
// Board-side bundle for position_alert_ctrl: raw switches and mute in, LED/encoder/buzzer status out.
// master = board/stimulus side, slave = controller side.
interface position_alert_if #(
  parameter int N_CH = 5
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] btn_in;
  logic            mute;
  logic [N_CH-1:0] leds;
  logic [PW-1:0]   pos_code;
  logic            pos_valid;
  logic            multi_err;
  logic            alert_active;
  logic            buzzer;

  modport master (
    output btn_in, mute,
    input  leds, pos_code, pos_valid, multi_err, alert_active, buzzer
  );
  modport slave (
    input  btn_in, mute,
    output leds, pos_code, pos_valid, multi_err, alert_active, buzzer
  );
endinterface

// File: rtl/position_alert_ctrl.sv
// Riding-position monitor: per-channel sync/debounce, position encoder, seat alert FSM with beeping buzzer.
// Optional build macro ESCALATE_EN: after a long ALERT dwell the beep becomes a continuous, faster tone.
module position_alert_deb #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          meta_q, sync_q, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input matches the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
endmodule

module position_alert_ctrl #(
  parameter int N_CH            = 5,
  parameter int ALERT_CH        = 4,
  parameter int DEBOUNCE_CYC    = 500000,
  parameter int ALERT_DELAY_CYC = 50000000,
  parameter int TONE_HALF       = 65536,
  parameter int BEEP_ON_CYC     = 12500000,
  parameter int BEEP_OFF_CYC    = 12500000,
  parameter int ESCALATE_CYC    = 250000000
) (
  input logic             clk,
  input logic             rst,
  position_alert_if.slave bus
);
  localparam int PW = $clog2(N_CH);
  localparam int DW = $clog2(ALERT_DELAY_CYC) + 1;
  localparam int TW = $clog2(TONE_HALF) + 1;
  localparam int BW = $clog2(BEEP_ON_CYC + BEEP_OFF_CYC) + 1;
  localparam logic [DW-1:0] DLY_LAST  = DW'(ALERT_DELAY_CYC - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [BW-1:0] BEEP_ON   = BW'(BEEP_ON_CYC);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_ON_CYC + BEEP_OFF_CYC - 1);

  if (N_CH < 2 || N_CH > 16 || ALERT_CH >= N_CH || DEBOUNCE_CYC < 1 || ALERT_DELAY_CYC < 1 ||
      TONE_HALF < 1 || BEEP_ON_CYC < 1 || BEEP_OFF_CYC < 1 || ESCALATE_CYC < 1) begin : g_bad_param
    $error("position_alert_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ARMED, ALERT} state_e;

  logic [N_CH-1:0] stable;
  logic [PW-1:0]   pos_code_q, pos_code_d;
  logic            pos_valid_q, pos_valid_d, multi_q, multi_d;
  state_e          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [TW-1:0]   tone_cnt_q, tone_cnt_d, tone_last;
  logic            tone_q, tone_d;
  logic [BW-1:0]   phase_q, phase_d;
  logic            buzzer_q, buzzer_d;
  logic            s, in_alert, esc, beep_on;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    position_alert_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_in[g]),
      .level (stable[g])
    );
  end

  // Scan high-to-low so the lowest active index is the last one written.
  always_comb begin
    pos_code_d  = '0;
    pos_valid_d = 1'b0;
    multi_d     = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (stable[i]) begin
        multi_d     = multi_d | pos_valid_d;
        pos_valid_d = 1'b1;
        pos_code_d  = PW'(i);
      end
    end
  end

  assign s        = stable[ALERT_CH];
  assign in_alert = (state_q == ALERT);

`ifdef ESCALATE_EN
  localparam int EW       = $clog2(ESCALATE_CYC) + 1;
  localparam int HALF_ESC = (TONE_HALF / 2 < 1) ? 1 : TONE_HALF / 2;
  localparam logic [EW-1:0] ESC_LAST      = EW'(ESCALATE_CYC - 1);
  localparam logic [TW-1:0] TONE_LAST_ESC = TW'(HALF_ESC - 1);

  logic [EW-1:0] dwell_q, dwell_d;
  logic          esc_q, esc_d;

  // Dwell saturates once escalated; leaving ALERT clears both.
  always_comb begin
    dwell_d = '0;
    esc_d   = 1'b0;
    if (in_alert && s) begin
      dwell_d = dwell_q;
      esc_d   = esc_q;
      if (!esc_q) begin
        if (dwell_q == ESC_LAST) esc_d   = 1'b1;
        else                     dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      esc_q   <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      esc_q   <= esc_d;
    end
  end

  assign esc       = esc_q;
  assign tone_last = esc_q ? TONE_LAST_ESC : TONE_LAST;
`else
  assign esc       = 1'b0;
  assign tone_last = TONE_LAST;
`endif

  assign beep_on = esc | (phase_q < BEEP_ON);

  // Tone/beep state only advances while ALERT is held, so re-entry always starts in the ON phase.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    tone_cnt_d = '0;
    tone_d     = 1'b0;
    phase_d    = '0;
    case (state_q)
      IDLE: if (s) begin
        state_d = ARMED;
        dly_d   = '0;
      end
      ARMED: begin
        if (!s)                    state_d = IDLE;
        else if (dly_q == DLY_LAST) state_d = ALERT;
        else                       dly_d   = dly_q + 1'b1;
      end
      ALERT: begin
        if (!s) state_d = IDLE;
        else begin
          tone_d  = tone_q;
          phase_d = (phase_q == BEEP_LAST) ? '0 : phase_q + 1'b1;
          // >= lets the count fall straight through when escalation shortens the half-period.
          if (tone_cnt_q >= tone_last) begin
            tone_d     = ~tone_q;
            tone_cnt_d = '0;
          end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    buzzer_d = in_alert & tone_q & beep_on & ~bus.mute;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_code_q  <= '0;
      pos_valid_q <= 1'b0;
      multi_q     <= 1'b0;
      state_q     <= IDLE;
      dly_q       <= '0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
      phase_q     <= '0;
      buzzer_q    <= 1'b0;
    end else begin
      pos_code_q  <= pos_code_d;
      pos_valid_q <= pos_valid_d;
      multi_q     <= multi_d;
      state_q     <= state_d;
      dly_q       <= dly_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_q      <= tone_d;
      phase_q     <= phase_d;
      buzzer_q    <= buzzer_d;
    end
  end

  assign bus.leds         = stable;
  assign bus.pos_code     = pos_code_q;
  assign bus.pos_valid    = pos_valid_q;
  assign bus.multi_err    = multi_q;
  assign bus.alert_active = in_alert;
  assign bus.buzzer       = buzzer_q;
endmodule

// File: tb/tb_position_alert_ctrl.sv
// Directed bench for position_alert_ctrl with short debounce/alert/tone timings.
// Build with ESCALATE_EN defined to also exercise the escalation path.
module tb_position_alert_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  position_alert_if #(.N_CH(5)) bus ();

  position_alert_ctrl #(
    .N_CH(5), .ALERT_CH(4), .DEBOUNCE_CYC(4), .ALERT_DELAY_CYC(10), .TONE_HALF(2),
    .BEEP_ON_CYC(8), .BEEP_OFF_CYC(8), .ESCALATE_CYC(40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Buzzer k cycles after ALERT entry: tone high on (k-1)%4 in {2,3}, gated by ON phase (k-1)%16 < 8.
  function automatic logic beep_exp(input int k);
    return (k >= 1) && (((k - 1) % 4) >= 2) && (((k - 1) % 16) < 8);
  endfunction

  // Seat on now; stable after 6 edges, ARMED 1 edge later, ALERT 10 edges after that.
  task automatic enter_alert();
    bus.btn_in = 5'b10000;
    step(16);
    chk("armed_not_yet", 32'(bus.alert_active), 32'd0);
    step(1);
    chk("alert_entry", 32'(bus.alert_active), 32'd1);
    chk("alert_pos_code", 32'(bus.pos_code), 32'd4);
  endtask

  task automatic chk_beep(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk($sformatf("beep_k%0d", k), 32'(bus.buzzer), 32'(beep_exp(k)));
      step(1);
    end
  endtask

  task automatic wait_alert_low(input int budget);
    int n = 0;
    while (bus.alert_active !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    chk("alert_exit", 32'(bus.alert_active), 32'd0);
  endtask

  initial begin
    logic acc, seen, prev;
    bus.btn_in = '0;
    bus.mute   = 1'b0;
    step(3);
    chk("rst_leds", 32'(bus.leds), 32'd0);
    chk("rst_pos_code", 32'(bus.pos_code), 32'd0);
    chk("rst_pos_valid", 32'(bus.pos_valid), 32'd0);
    chk("rst_multi", 32'(bus.multi_err), 32'd0);
    chk("rst_alert", 32'(bus.alert_active), 32'd0);
    chk("rst_buzzer", 32'(bus.buzzer), 32'd0);
    rst = 1'b0;
    step(2);

    // 3-cycle glitch is rejected.
    bus.btn_in = 5'b00100;
    step(3);
    bus.btn_in = '0;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acc = acc | (|bus.leds) | bus.pos_valid;
    end
    chk("glitch3_ignored", 32'(acc), 32'd0);

    // 4-cycle pulse is exactly long enough to be accepted.
    bus.btn_in = 5'b00001;
    step(4);
    bus.btn_in = '0;
    step(2);
    chk("pulse4_accepted", 32'(bus.leds), 32'h01);
    step(12);
    chk("pulse4_released", 32'(bus.leds), 32'h00);

    // Single channel: leds at edge 6, encoder one edge later.
    bus.btn_in = 5'b00010;
    step(5);
    chk("lat_edge5", 32'(bus.leds), 32'h00);
    step(1);
    chk("lat_edge6", 32'(bus.leds), 32'h02);
    chk("enc_lags", 32'(bus.pos_valid), 32'd0);
    step(1);
    chk("one_code", 32'(bus.pos_code), 32'd1);
    chk("one_valid", 32'(bus.pos_valid), 32'd1);
    chk("one_multi", 32'(bus.multi_err), 32'd0);

    bus.btn_in = 5'b00110;
    step(7);
    chk("two_leds", 32'(bus.leds), 32'h06);
    chk("two_code", 32'(bus.pos_code), 32'd1);
    chk("two_multi", 32'(bus.multi_err), 32'd1);

    bus.btn_in = '0;
    step(8);
    chk("none_valid", 32'(bus.pos_valid), 32'd0);
    chk("none_code", 32'(bus.pos_code), 32'd0);

    // Full alert: entry timing, beep pattern, mute, then FSM still running after unmute.
    enter_alert();
    chk_beep(32);
    bus.mute = 1'b1;
    acc  = 1'b0;
    seen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      acc  = acc | bus.buzzer;
      seen = seen & bus.alert_active;
    end
    chk("mute_silent", 32'(acc), 32'd0);
    chk("mute_alert_held", 32'(seen), 32'd1);
    bus.mute = 1'b0;
`ifdef ESCALATE_EN
    step(1);
    prev = bus.buzzer;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("esc_toggle", 32'(bus.buzzer), 32'(~prev));
      prev = bus.buzzer;
    end
`else
    for (int k = 49; k <= 64; k++) begin
      step(1);
      chk($sformatf("unmute_k%0d", k), 32'(bus.buzzer), 32'(beep_exp(k)));
    end
`endif

    bus.btn_in = '0;
    wait_alert_low(20);
    step(1);
    chk("exit_buzzer", 32'(bus.buzzer), 32'd0);

    // Re-entry restarts beep pattern (and clears any escalation).
    enter_alert();
    chk_beep(20);
    bus.btn_in = '0;
    wait_alert_low(20);
    step(4);

    // Seat drops so the debounced level falls in the ARMED expiry cycle: IDLE wins.
    bus.btn_in = 5'b10000;
    step(10);
    bus.btn_in = '0;
    acc  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      acc  = acc | bus.alert_active;
      seen = seen | bus.leds[4];
    end
    chk("expiry_seat_seen", 32'(seen), 32'd1);
    chk("expiry_idle_wins", 32'(acc), 32'd0);

    // Async reset while buzzer is high.
    enter_alert();
    begin
      int n = 0;
      while (bus.buzzer !== 1'b1 && n < 20) begin
        step(1);
        n++;
      end
    end
    chk("pre_rst_buzzer", 32'(bus.buzzer), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_buzzer", 32'(bus.buzzer), 32'd0);
    chk("arst_alert", 32'(bus.alert_active), 32'd0);
    chk("arst_leds", 32'(bus.leds), 32'd0);
    chk("arst_valid", 32'(bus.pos_valid), 32'd0);
    chk("arst_code", 32'(bus.pos_code), 32'd0);
    bus.btn_in = '0;
    step(2);
    rst = 1'b0;
    step(8);
    chk("post_rst_alert", 32'(bus.alert_active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
